// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD to binary converter:
// FSM state encoding, BCD digit constants and the result-width helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } bcd_state_e;

   localparam int         BCD_DIGIT_W   = 4;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   // Smallest result width able to hold 10^digits - 1.
   function automatic int bcd_min_bin_w(input int digits);
      longint unsigned max_val;
      int              w;
      max_val = 64'd1;
      w       = 0;
      for (int i = 0; i < digits; i++) begin
         max_val = max_val * 64'd10;
      end
      max_val = max_val - 64'd1;
      while (max_val != 64'd0) begin
         max_val = max_val >> 1;
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for bcd_to_bin_seq: BCD word in, binary result out.
// master = upstream/downstream side driving the converter, slave = converter.
interface bcd_to_bin_seq_if #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);

   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_bcd;
   logic                  out_valid;
   logic                  out_ready;
   logic [BIN_W-1:0]      out_bin;
   logic                  out_err;

   modport master (
      output in_valid,
      output in_bcd,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_bin,
      input  out_err
   );

   modport slave (
      input  in_valid,
      input  in_bcd,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_bin,
      output out_err
   );

endinterface

// File: rtl/bcd_mac10.sv
// One decimal fold step: acc*10 + digit, truncated to BIN_W bits.
// The multiply by ten is built from two shifts and an add.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic [BIN_W-1:0]       acc_i,
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BIN_W-1:0]       sum_o
);

   // (acc<<3) + (acc<<1) + digit, all carried at BIN_W bits.
   always_comb begin
      sum_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter. Folds one digit per cycle,
// most significant first. Optional illegal-digit detection is enabled by
// defining BCD2BIN_DIGIT_CHECK_EN; otherwise out_err is tied low and
// illegal digits are folded as their raw 4-bit value.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_to_bin_seq_if.slave   bus_if
);

   localparam int SR_W  = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Reject configurations that cannot hold the largest legal value.
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_to_bin_seq: DIGITS must be in 1..8");
   end
   if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bad_bin_w
      $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
   end

   bcd_state_e                state_q, state_d;
   logic [SR_W-1:0]           sr_q, sr_d;
   logic [BIN_W-1:0]          acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BCD_DIGIT_W-1:0]    digit;
   logic [BIN_W-1:0]          mac_sum;
   logic                      accept;
   logic                      done;

   assign digit  = sr_q[SR_W-1 -: BCD_DIGIT_W];
   assign accept = (state_q == IDLE) && bus_if.in_valid;
   assign done   = (state_q == DONE);

   bcd_mac10 #(
      .BIN_W (BIN_W)
   ) u_mac10 (
      .acc_i   (acc_q),
      .digit_i (digit),
      .sum_o   (mac_sum)
   );

   // Next state and datapath update: load on accept, fold while converting,
   // hold the result until the downstream takes it.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus_if.in_valid) begin
               sr_d    = bus_if.in_bcd;
               acc_d   = '0;
               cnt_d   = CNT_W'(DIGITS - 1);
               state_d = CONV;
            end
         end
         CONV: begin
            acc_d = mac_sum;
            sr_d  = sr_q << BCD_DIGIT_W;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus_if.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus_if.in_ready  = (state_q == IDLE);
   assign bus_if.out_valid = done;

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic err_q, err_d;

   // Sticky illegal-digit flag, cleared when a new word is accepted.
   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = 1'b0;
      end else if ((state_q == CONV) && (digit > BCD_MAX_DIGIT)) begin
         err_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   // A flagged conversion presents zero rather than a meaningless value.
   assign bus_if.out_err = done && err_q;
   assign bus_if.out_bin = (done && !err_q) ? acc_q : '0;
`else
   assign bus_if.out_err = 1'b0;
   assign bus_if.out_bin = done ? acc_q : '0;
`endif

endmodule
